// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: ALU offer, load issue/response, register-file write port.
// Optional WB_FAULT_CAPTURE_EN adds fault_clr, fault_sticky and fault_rd.
interface wb_arbiter_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_result;
   logic        alu_ready;
   logic        ld_issue_valid;
   logic [4:0]  ld_issue_rd;
   logic [2:0]  ld_issue_funct3;
   logic [1:0]  ld_issue_off;
   logic        ld_issue_ready;
   logic        ld_rsp_valid;
   logic [31:0] ld_rsp_data;
   logic        ld_rsp_fault;
   logic        rg_wrt_en;
   logic [4:0]  rg_wrt_addr;
   logic [31:0] rg_wrt_data;
   logic [31:0] busy_mask;
   logic        ld_fault;
   logic        proto_err;
`ifdef WB_FAULT_CAPTURE_EN
   logic        fault_clr;
   logic        fault_sticky;
   logic [4:0]  fault_rd;

   modport slave (
      input  alu_valid, alu_rd, alu_result, ld_issue_valid, ld_issue_rd, ld_issue_funct3,
             ld_issue_off, ld_rsp_valid, ld_rsp_data, ld_rsp_fault, fault_clr,
      output alu_ready, ld_issue_ready, rg_wrt_en, rg_wrt_addr, rg_wrt_data, busy_mask,
             ld_fault, proto_err, fault_sticky, fault_rd
   );
   modport master (
      output alu_valid, alu_rd, alu_result, ld_issue_valid, ld_issue_rd, ld_issue_funct3,
             ld_issue_off, ld_rsp_valid, ld_rsp_data, ld_rsp_fault, fault_clr,
      input  alu_ready, ld_issue_ready, rg_wrt_en, rg_wrt_addr, rg_wrt_data, busy_mask,
             ld_fault, proto_err, fault_sticky, fault_rd
   );
`else
   modport slave (
      input  alu_valid, alu_rd, alu_result, ld_issue_valid, ld_issue_rd, ld_issue_funct3,
             ld_issue_off, ld_rsp_valid, ld_rsp_data, ld_rsp_fault,
      output alu_ready, ld_issue_ready, rg_wrt_en, rg_wrt_addr, rg_wrt_data, busy_mask,
             ld_fault, proto_err
   );
   modport master (
      output alu_valid, alu_rd, alu_result, ld_issue_valid, ld_issue_rd, ld_issue_funct3,
             ld_issue_off, ld_rsp_valid, ld_rsp_data, ld_rsp_fault,
      input  alu_ready, ld_issue_ready, rg_wrt_en, rg_wrt_addr, rg_wrt_data, busy_mask,
             ld_fault, proto_err
   );
`endif
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: load responses (matched against an in-order pending-load FIFO) beat
// stallable ALU results onto the register-file write port. Macro WB_FAULT_CAPTURE_EN adds fault capture.
module wb_arbiter #(
   parameter int LQ_DEPTH = 4
) (
   input logic        clk,
   input logic        reset,
   wb_arbiter_if.slave bus
);
   localparam int PW = $clog2(LQ_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [1:0] off;
   } lq_entry_t;

   lq_entry_t          lq_q [LQ_DEPTH];
   lq_entry_t          lq_d [LQ_DEPTH];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               rg_wrt_en_q, rg_wrt_en_d;
   logic [4:0]         rg_wrt_addr_q, rg_wrt_addr_d;
   logic [31:0]        rg_wrt_data_q, rg_wrt_data_d;
   logic               ld_fault_q, ld_fault_d;
   logic               proto_err_q, proto_err_d;

   lq_entry_t          head;
   logic               lq_empty, lq_full, push, pop;
   logic [31:0]        busy;

   function automatic logic [31:0] fmt_load(logic [31:0] d, logic [2:0] f3, logic [1:0] off);
      logic [31:0] sh;
      sh = d >> {off, 3'b000};
      case (f3)
         3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
         3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
         3'b100:  fmt_load = {24'h0, sh[7:0]};
         3'b101:  fmt_load = {16'h0, sh[15:0]};
         default: fmt_load = d;
      endcase
   endfunction

   assign head     = lq_q[rd_ptr_q];
   assign lq_empty = (count_q == '0);
   assign lq_full  = (count_q == CW'(LQ_DEPTH));
   // A response with nothing queued never pops, so it does not steal the port from the ALU.
   assign pop      = bus.ld_rsp_valid && !lq_empty;
   assign push     = bus.ld_issue_valid && !lq_full;

   assign bus.alu_ready      = !pop;
   assign bus.ld_issue_ready = !lq_full;
   assign bus.rg_wrt_en      = rg_wrt_en_q;
   assign bus.rg_wrt_addr    = rg_wrt_addr_q;
   assign bus.rg_wrt_data    = rg_wrt_data_q;
   assign bus.ld_fault       = ld_fault_q;
   assign bus.proto_err      = proto_err_q;
   assign bus.busy_mask      = busy;

   // Slot i is live when its distance from the read pointer is below the count.
   always_comb begin
      busy = '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (CW'(i) < count_q)
            busy[lq_q[rd_ptr_q + PW'(i)].rd] = 1'b1;
      end
      busy[0] = 1'b0;
   end

   always_comb begin
      lq_d          = lq_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q + CW'(push) - CW'(pop);
      rg_wrt_en_d   = 1'b0;
      rg_wrt_addr_d = rg_wrt_addr_q;
      rg_wrt_data_d = rg_wrt_data_q;
      ld_fault_d    = 1'b0;
      proto_err_d   = bus.ld_rsp_valid && lq_empty;

      if (push) begin
         lq_d[wr_ptr_q] = '{rd: bus.ld_issue_rd, funct3: bus.ld_issue_funct3, off: bus.ld_issue_off};
         wr_ptr_d       = wr_ptr_q + PW'(1);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         if (bus.ld_rsp_fault) begin
            ld_fault_d = 1'b1;
         end else if (head.rd != 5'd0) begin
            rg_wrt_en_d   = 1'b1;
            rg_wrt_addr_d = head.rd;
            rg_wrt_data_d = fmt_load(bus.ld_rsp_data, head.funct3, head.off);
         end
      end else if (bus.alu_valid && bus.alu_rd != 5'd0) begin
         rg_wrt_en_d   = 1'b1;
         rg_wrt_addr_d = bus.alu_rd;
         rg_wrt_data_d = bus.alu_result;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LQ_DEPTH; i++) lq_q[i] <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         rg_wrt_en_q   <= 1'b0;
         rg_wrt_addr_q <= '0;
         rg_wrt_data_q <= '0;
         ld_fault_q    <= 1'b0;
         proto_err_q   <= 1'b0;
      end else begin
         lq_q          <= lq_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         rg_wrt_en_q   <= rg_wrt_en_d;
         rg_wrt_addr_q <= rg_wrt_addr_d;
         rg_wrt_data_q <= rg_wrt_data_d;
         ld_fault_q    <= ld_fault_d;
         proto_err_q   <= proto_err_d;
      end
   end

`ifdef WB_FAULT_CAPTURE_EN
   logic       fault_sticky_q, fault_sticky_d;
   logic [4:0] fault_rd_q, fault_rd_d;

   // A clear and a new fault in the same cycle leave the new fault captured.
   always_comb begin
      fault_sticky_d = fault_sticky_q;
      fault_rd_d     = fault_rd_q;
      if (bus.fault_clr) begin
         fault_sticky_d = 1'b0;
         fault_rd_d     = '0;
      end
      if (pop && bus.ld_rsp_fault && (!fault_sticky_q || bus.fault_clr)) begin
         fault_sticky_d = 1'b1;
         fault_rd_d     = head.rd;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_sticky_q <= 1'b0;
         fault_rd_q     <= '0;
      end else begin
         fault_sticky_q <= fault_sticky_d;
         fault_rd_q     <= fault_rd_d;
      end
   end

   assign bus.fault_sticky = fault_sticky_q;
   assign bus.fault_rd     = fault_rd_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand-written reset/fault sequences, then
// random traffic checked against a queue-based reference model.
module tb_wb_arbiter;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   wb_arbiter_if bus();
   wb_arbiter #(.LQ_DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [4:0] rd;
      logic [2:0] f3;
      logic [1:0] off;
   } ld_t;

   typedef struct {
      logic        av;  logic [4:0] ard; logic [31:0] ares;
      logic        iv;  logic [4:0] ird; logic [2:0]  if3; logic [1:0] ioff;
      logic        rv;  logic [31:0] rdata; logic rf; logic fclr;
      logic        e_ar, e_ir; logic [31:0] e_busy;
      logic        e_we; logic [4:0] e_wa; logic [31:0] e_wd; logic e_fault, e_perr;
   } vec_t;

   vec_t vt[$];

   // Reference model state
   ld_t         mq[$];
   logic        m_we, m_fault, m_perr, m_sticky;
   logic [4:0]  m_wa, m_frd;
   logic [31:0] m_wd;

   function automatic vec_t v(logic av, logic [4:0] ard, logic [31:0] ares,
                              logic iv, logic [4:0] ird, logic [2:0] if3, logic [1:0] ioff,
                              logic rv, logic [31:0] rdata, logic rf,
                              logic e_ar, logic e_ir, logic [31:0] e_busy,
                              logic e_we, logic [4:0] e_wa, logic [31:0] e_wd,
                              logic e_fault, logic e_perr);
      vec_t r;
      r.av = av; r.ard = ard; r.ares = ares;
      r.iv = iv; r.ird = ird; r.if3 = if3; r.ioff = ioff;
      r.rv = rv; r.rdata = rdata; r.rf = rf; r.fclr = 1'b0;
      r.e_ar = e_ar; r.e_ir = e_ir; r.e_busy = e_busy;
      r.e_we = e_we; r.e_wa = e_wa; r.e_wd = e_wd; r.e_fault = e_fault; r.e_perr = e_perr;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t s);
      bus.alu_valid       = s.av;
      bus.alu_rd          = s.ard;
      bus.alu_result      = s.ares;
      bus.ld_issue_valid  = s.iv;
      bus.ld_issue_rd     = s.ird;
      bus.ld_issue_funct3 = s.if3;
      bus.ld_issue_off    = s.ioff;
      bus.ld_rsp_valid    = s.rv;
      bus.ld_rsp_data     = s.rdata;
      bus.ld_rsp_fault    = s.rf;
`ifdef WB_FAULT_CAPTURE_EN
      bus.fault_clr       = s.fclr;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Arithmetic view of load extraction: pick the byte/halfword value, fold into two's complement.
   function automatic logic [31:0] ref_fmt(logic [31:0] d, logic [2:0] f3, logic [1:0] off);
      int unsigned b, h;
      b = (d >> (8 * off)) % 256;
      h = (d >> (8 * off)) % 65536;
      case (f3)
         3'd0:    return (b >= 128)   ? 32'(b) - 32'd256   : 32'(b);
         3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
         3'd4:    return 32'(b);
         3'd5:    return 32'(h);
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] ref_busy();
      logic [31:0] m = 0;
      foreach (mq[i]) if (mq[i].rd != 0) m = m | (32'd1 << mq[i].rd);
      return m;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_we = 0; m_fault = 0; m_perr = 0; m_wa = 0; m_wd = 0; m_sticky = 0; m_frd = 0;
   endtask

   task automatic model_step(input vec_t s);
      ld_t e;
      bit  was_full, popped, old_sticky;
      was_full   = (mq.size() == D);
      popped     = 0;
      old_sticky = m_sticky;
      m_we = 0; m_fault = 0; m_perr = 0;
      if (s.fclr) begin m_sticky = 0; m_frd = 0; end
      if (s.rv) begin
         if (mq.size() == 0) m_perr = 1;
         else begin
            e = mq.pop_front();
            popped = 1;
            if (s.rf) begin
               m_fault = 1;
               if (!old_sticky || s.fclr) begin m_sticky = 1; m_frd = e.rd; end
            end else if (e.rd != 0) begin
               m_we = 1; m_wa = e.rd; m_wd = ref_fmt(s.rdata, e.f3, e.off);
            end
         end
      end
      if (!popped && s.av && s.ard != 0) begin m_we = 1; m_wa = s.ard; m_wd = s.ares; end
      if (s.iv && !was_full) begin
         e.rd = s.ird; e.f3 = s.if3; e.off = s.ioff;
         mq.push_back(e);
      end
   endtask

   function automatic vec_t idle();
      return v(0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
   endfunction

   function automatic vec_t iss(logic [4:0] rd, logic [2:0] f3, logic [1:0] off);
      vec_t r = idle();
      r.iv = 1; r.ird = rd; r.if3 = f3; r.ioff = off;
      return r;
   endfunction

   function automatic vec_t rsp(logic [31:0] d, logic f);
      vec_t r = idle();
      r.rv = 1; r.rdata = d; r.rf = f;
      return r;
   endfunction

   initial begin
      vec_t        s;
      logic        cur_av, alu_hold, exp_ar;
      logic [4:0]  cur_ard;
      logic [31:0] cur_ares;

      //        av rd  res      iv rd f3 off  rv data          rf  ar ir busy      we wa wd            flt perr
      vt.push_back(v(0,0,0,        1,5,0,2,  0,0,0,              1,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'h00800000,0,   0,1,32'h20,    1,5,32'hFFFFFF80,0,0));
      vt.push_back(v(0,0,0,        1,5,4,2,  0,0,0,              1,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'h00800000,0,   0,1,32'h20,    1,5,32'h00000080,0,0));
      vt.push_back(v(0,0,0,        1,7,2,0,  0,0,0,              1,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(1,3,32'h1234, 0,0,0,0,  1,32'hDEADBEEF,0,   0,1,32'h80,    1,7,32'hDEADBEEF,0,0));
      vt.push_back(v(1,3,32'h1234, 0,0,0,0,  0,0,0,              1,1,32'h0,     1,3,32'h00001234,0,0));
      vt.push_back(v(0,0,0,        1,1,2,0,  0,0,0,              1,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        1,2,2,0,  0,0,0,              1,1,32'h2,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        1,2,2,0,  0,0,0,              1,1,32'h6,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        1,4,2,0,  0,0,0,              1,1,32'h6,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        1,9,2,0,  1,32'h11111111,0,   0,0,32'h16,    1,1,32'h11111111,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  0,0,0,              1,1,32'h14,    0,0,0,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'h22222222,1,   0,1,32'h14,    0,0,0,1,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'h33333333,0,   0,1,32'h14,    1,2,32'h33333333,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'h44444444,0,   0,1,32'h10,    1,4,32'h44444444,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  0,0,0,              1,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        1,0,2,0,  0,0,0,              1,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'h00000055,0,   0,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'h00000077,0,   1,1,32'h0,     0,0,0,0,1));
      vt.push_back(v(0,0,0,        1,6,2,0,  1,32'h00000099,0,   1,1,32'h0,     0,0,0,0,1));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'h00000066,0,   0,1,32'h40,    1,6,32'h00000066,0,0));
      vt.push_back(v(0,0,0,        1,10,1,2, 0,0,0,              1,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'h80010000,0,   0,1,32'h400,   1,10,32'hFFFF8001,0,0));
      vt.push_back(v(0,0,0,        1,11,5,0, 0,0,0,              1,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'h0000F00F,0,   0,1,32'h800,   1,11,32'h0000F00F,0,0));
      vt.push_back(v(0,0,0,        1,12,2,3, 0,0,0,              1,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'hCAFEF00D,0,   0,1,32'h1000,  1,12,32'hCAFEF00D,0,0));
      vt.push_back(v(0,0,0,        1,13,7,1, 0,0,0,              1,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'h01020304,0,   0,1,32'h2000,  1,13,32'h01020304,0,0));
      vt.push_back(v(1,0,32'hFFFF, 0,0,0,0,  0,0,0,              1,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        1,14,0,3, 0,0,0,              1,1,32'h0,     0,0,0,0,0));
      vt.push_back(v(0,0,0,        0,0,0,0,  1,32'h7F000000,0,   0,1,32'h4000,  1,14,32'h0000007F,0,0));

      // Reset state
      drive(idle());
      reset = 1'b1;
      #12;
      chk("rst_we", bus.rg_wrt_en, 0);
      chk("rst_wa", bus.rg_wrt_addr, 0);
      chk("rst_wd", bus.rg_wrt_data, 0);
      chk("rst_fault", bus.ld_fault, 0);
      chk("rst_perr", bus.proto_err, 0);
      chk("rst_busy", bus.busy_mask, 0);
      chk("rst_ir", bus.ld_issue_ready, 1);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("rst_ar", bus.alu_ready, 1);
      tick();

      foreach (vt[i]) begin
         drive(vt[i]);
         #1;
         chk($sformatf("vec%0d_alu_ready", i), bus.alu_ready, vt[i].e_ar);
         chk($sformatf("vec%0d_issue_ready", i), bus.ld_issue_ready, vt[i].e_ir);
         chk($sformatf("vec%0d_busy", i), bus.busy_mask, vt[i].e_busy);
         tick();
         chk($sformatf("vec%0d_we", i), bus.rg_wrt_en, vt[i].e_we);
         if (vt[i].e_we) begin
            chk($sformatf("vec%0d_wa", i), bus.rg_wrt_addr, vt[i].e_wa);
            chk($sformatf("vec%0d_wd", i), bus.rg_wrt_data, vt[i].e_wd);
         end
         chk($sformatf("vec%0d_fault", i), bus.ld_fault, vt[i].e_fault);
         chk($sformatf("vec%0d_perr", i), bus.proto_err, vt[i].e_perr);
      end

`ifdef WB_FAULT_CAPTURE_EN
      // First fault (rd=2) stays captured; a later fault does not overwrite it.
      drive(idle()); #1;
      chk("cap_sticky", bus.fault_sticky, 1);
      chk("cap_rd", bus.fault_rd, 2);
      drive(iss(9, 2, 0)); tick();
      drive(rsp(32'h0, 1)); tick();
      chk("cap_hold_rd", bus.fault_rd, 2);
      drive(iss(11, 2, 0)); tick();
      s = rsp(32'h0, 1); s.fclr = 1; drive(s); tick();
      chk("cap_clr_new_sticky", bus.fault_sticky, 1);
      chk("cap_clr_new_rd", bus.fault_rd, 11);
      s = idle(); s.fclr = 1; drive(s); tick();
      chk("cap_clr_sticky", bus.fault_sticky, 0);
`endif

      // Reset with loads queued and a write on the port: everything clears asynchronously.
      drive(iss(1, 2, 0)); tick();
      drive(iss(2, 2, 0)); tick();
      drive(iss(3, 2, 0)); tick();
      s = rsp(32'hA5A5A5A5, 0); s.iv = 1; s.ird = 8; s.if3 = 2; drive(s); tick();
      chk("pre_rst_we", bus.rg_wrt_en, 1);
      chk("pre_rst_busy", bus.busy_mask, 32'h10C);
      drive(idle());
      #2 reset = 1'b1;
      #1;
      chk("arst_we", bus.rg_wrt_en, 0);
      chk("arst_wa", bus.rg_wrt_addr, 0);
      chk("arst_wd", bus.rg_wrt_data, 0);
      chk("arst_busy", bus.busy_mask, 0);
      chk("arst_ir", bus.ld_issue_ready, 1);
      #1 reset = 1'b0;
      drive(rsp(32'h12345678, 0)); #1;
      chk("post_rst_ar", bus.alu_ready, 1);
      tick();
      chk("post_rst_perr", bus.proto_err, 1);
      chk("post_rst_we", bus.rg_wrt_en, 0);
      drive(idle()); tick();
      chk("post_rst_perr_pulse", bus.proto_err, 0);

      // Random traffic against the model; the ALU holds its offer until accepted.
      model_reset();
      alu_hold = 0; cur_av = 0; cur_ard = 0; cur_ares = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!alu_hold) begin
            cur_av   = ($urandom_range(0, 99) < 60);
            cur_ard  = 5'($urandom);
            cur_ares = $urandom;
         end
         s = idle();
         s.av = cur_av; s.ard = cur_ard; s.ares = cur_ares;
         s.iv = ($urandom_range(0, 99) < 50);
         s.ird = 5'($urandom); s.if3 = 3'($urandom); s.ioff = 2'($urandom);
         s.rv = ($urandom_range(0, 99) < 45);
         s.rdata = $urandom;
         s.rf = ($urandom_range(0, 99) < 10);
         s.fclr = ($urandom_range(0, 99) < 5);
         drive(s);
         #1;
         exp_ar = !(s.rv && mq.size() > 0);
         chk("rnd_alu_ready", bus.alu_ready, exp_ar);
         chk("rnd_issue_ready", bus.ld_issue_ready, mq.size() != D);
         chk("rnd_busy", bus.busy_mask, ref_busy());
         model_step(s);
         alu_hold = cur_av && !exp_ar;
         tick();
         chk("rnd_we", bus.rg_wrt_en, m_we);
         if (m_we) begin
            chk("rnd_wa", bus.rg_wrt_addr, m_wa);
            chk("rnd_wd", bus.rg_wrt_data, m_wd);
         end
         chk("rnd_fault", bus.ld_fault, m_fault);
         chk("rnd_perr", bus.proto_err, m_perr);
`ifdef WB_FAULT_CAPTURE_EN
         chk("rnd_sticky", bus.fault_sticky, m_sticky);
         chk("rnd_frd", bus.fault_rd, m_frd);
`endif
         if (c % 700 == 350) begin
            #2 reset = 1'b1;
            #1;
            model_reset();
            chk("rnd_rst_we", bus.rg_wrt_en, 0);
            chk("rnd_rst_busy", bus.busy_mask, 0);
            chk("rnd_rst_ir", bus.ld_issue_ready, 1);
            #1 reset = 1'b0;
            alu_hold = 0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

- Writeback stage that drives the single write port of the integer register file (x0–x31).
- Sources:
  - Single-cycle ALU results, which can be stalled.
  - In-order load responses from the memory/PMP path, which cannot be stalled. They are matched against a queue of issued loads, then byte-selected and sign/zero-extended.
- Exports a busy mask of registers with outstanding loads, for upstream hazard detection.

## Interface
- LQ_DEPTH, 4: pending-load queue entries (power of two, 2–16).
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU result offered this cycle.
- alu_rd  input  5  ALU destination register.
- alu_result  input  32  ALU result.
- alu_ready  output  1  ALU result accepted this cycle.
- ld_issue_valid  input  1  load issued to memory.
- ld_issue_rd  input  5  load destination register.
- ld_issue_funct3  input  3  load type.
- ld_issue_off  input  2  byte offset, addr[1:0].
- ld_issue_ready  output  1  queue not full.
- ld_rsp_valid  input  1  memory response (single-cycle pulse, not back-pressurable).
- ld_rsp_data  input  32  raw aligned word.
- ld_rsp_fault  input  1  PMP/access fault on this response.
- rg_wrt_en  output  1  register write enable.
- rg_wrt_addr  output  5  destination address.
- rg_wrt_data  output  32  write data.
- busy_mask  output  32  bit r set while a load to xr is queued.
- ld_fault  output  1  one-cycle pulse on faulted response.
- proto_err  output  1  one-cycle pulse on response with empty queue.

## Operation
- Pending-load queue (FIFO):
  - Entry is {rd, funct3, off}.
  - Push on ld_issue_valid && ld_issue_ready.
  - Pop on ld_rsp_valid when the queue is non-empty.
- Arbitration:
  - A load response always wins.
  - alu_ready = !(ld_rsp_valid && count != 0).
  - A stalled ALU holds its inputs stable until accepted.
- Load formatting, with shifted = ld_rsp_data >> (8*off):
  - 000 LB: sign-extend shifted[7:0].
  - 001 LH: sign-extend shifted[15:0].
  - 100 LBU: zero-extend shifted[7:0].
  - 101 LHU: zero-extend shifted[15:0].
  - 010 LW and all other codes: full ld_rsp_data, off ignored.
  - Misalignment checking is the issuer's responsibility.
- Write suppression:
  - rd == 0 never asserts rg_wrt_en. The queue still pops and the ALU is still accepted.
  - A faulted response pops its entry, performs no write, and pulses ld_fault.
- busy_mask:
  - OR of the one-hot rd of all valid entries; bit 0 is forced to 0.
  - Duplicate rds are allowed. A bit clears only when no remaining entry targets that register.
- Response with empty queue: ignored and pulses proto_err. The ALU is not stalled (alu_ready stays high).

## Timing
- rg_wrt_en, rg_wrt_addr, rg_wrt_data, ld_fault and proto_err are registered. The write appears one cycle after the accepting edge, and rg_wrt_en is high for exactly one cycle per write.
- ld_issue_ready = (count != LQ_DEPTH), from registered count.
  - If an issue and a response arrive in the same cycle when full, the pop happens and the issue is still rejected.
  - If they arrive in the same cycle when empty, the response is a proto_err and the issue is pushed.
- busy_mask is combinational from the queue registers. A push is visible the cycle after issue; a pop clears the bit in the same cycle as the rg_wrt_en assertion.
- Pointers wrap modulo LQ_DEPTH, and count is a (log2(LQ_DEPTH)+1)-bit value.
- Reset (asynchronous, any time):
  - Queue emptied and busy_mask = 0.
  - rg_wrt_en = 0, rg_wrt_addr = 0, rg_wrt_data = 0, ld_fault = 0, proto_err = 0.
  - ld_issue_ready = 1, and alu_ready = 1 once reset deasserts.
  - Loads in flight at reset are discarded; their later responses raise proto_err.

## Configuration
- WB_FAULT_CAPTURE_EN defined:
  - Adds input fault_clr (1), and outputs fault_sticky (1) and fault_rd (5), both reset to 0.
  - The first faulted response sets fault_sticky and captures its rd. Later faults do not overwrite the capture until a fault_clr pulse.
  - If fault_clr and a new fault coincide, the new fault is captured.
- WB_FAULT_CAPTURE_EN undefined: none of these ports exist; a fault only pulses ld_fault.

## Test plan
- LB/LBU sign handling: issue LB rd=5 off=2, respond 0x00800000 -> next cycle rg_wrt_en=1, addr=5, data=0xFFFFFF80. Repeat as LBU -> data=0x00000080.
- Collision: ALU rd=3 value 0x1234 held valid while a response for queued LW rd=7 (0xDEADBEEF) arrives -> alu_ready=0, cycle+1 writes x7=0xDEADBEEF. Next cycle alu_ready=1, and cycle+2 writes x3=0x1234.
- Full queue: 4 issues to rd 1,2,2,4 -> ld_issue_ready=0 and busy_mask=0x16. A fifth issue coinciding with the first response is rejected, and busy_mask becomes 0x14.
- Fault and x0: response with ld_rsp_fault=1 -> no write, ld_fault pulse, fault_sticky=1 with fault_rd captured (macro on). A load to rd=0 -> no rg_wrt_en, queue pops.
- Protocol and reset: response with empty queue -> proto_err pulse, no write. Assert reset with 3 loads queued -> busy_mask=0, ld_issue_ready=1, all outputs 0 immediately.
